// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - handshaked ALU: single-cycle data-processing ops, iterative mul/mla, NZCV flags
// Each result is held in DONE until the writeback stage takes it.
module pipelined_alu #(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_CYCLES = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [3:0]            opcode_i,
   input  logic                  is_mul_i,
   input  logic                  accumulate_i,
   input  logic                  set_flags_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [DATA_WIDTH-1:0] c_i,
   input  logic [3:0]            flags_in_i,
   input  logic [TAG_WIDTH-1:0]  tag_in_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [3:0]            flags_out_o,
   output logic                  flags_we_o,
   output logic                  result_we_o,
   output logic [TAG_WIDTH-1:0]  tag_out_o,
   output logic                  busy_o
);
   // Multiplier bits consumed per clock so the product completes in MUL_CYCLES steps
   localparam int CHUNK = (DATA_WIDTH + MUL_CYCLES - 1) / MUL_CYCLES;
   localparam int CW    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic                  msf_q, msf_d;
   logic [3:0]            mflags_q, mflags_d;
   logic [TAG_WIDTH-1:0]  mtag_q, mtag_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic [3:0]            fout_q, fout_d;
   logic                  fwe_q, fwe_d;
   logic                  rwe_q, rwe_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;

   logic                  accept;
   logic [DATA_WIDTH-1:0] add_x, add_y, logic_res, alu_res;
   logic                  add_cin, is_arith, is_test, alu_c, alu_v, alu_fwe;
   logic [DATA_WIDTH:0]   sum;
   logic [3:0]            alu_flags;

   logic [DATA_WIDTH-1:0] step_acc_in, step_mcand, step_mplier, chunk_ext, step_acc;
   logic                  mul_sf;
   logic [3:0]            mul_fin, mul_flags;
   logic [TAG_WIDTH-1:0]  mul_tag;

   assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = (state_q == S_DONE);
   assign busy_o      = (state_q != S_IDLE);
   assign result_o    = res_q;
   assign flags_out_o = fout_q;
   assign flags_we_o  = fwe_q;
   assign result_we_o = rwe_q;
   assign tag_out_o   = tag_q;

   // Subtracts are folded into one adder as x + ~y + cin, so carry out is NOT borrow
   always_comb begin
      add_x     = a_i;
      add_y     = b_i;
      add_cin   = 1'b0;
      is_arith  = 1'b1;
      logic_res = '0;
      case (opcode_i)
         OP_AND, OP_TST: begin is_arith = 1'b0; logic_res = a_i & b_i; end
         OP_EOR, OP_TEQ: begin is_arith = 1'b0; logic_res = a_i ^ b_i; end
         OP_SUB, OP_CMP: begin add_y = ~b_i; add_cin = 1'b1; end
         OP_RSB:         begin add_x = b_i; add_y = ~a_i; add_cin = 1'b1; end
         OP_ADD, OP_CMN: begin add_cin = 1'b0; end
         OP_ADC:         begin add_cin = flags_in_i[1]; end
         OP_SBC:         begin add_y = ~b_i; add_cin = flags_in_i[1]; end
         OP_RSC:         begin add_x = b_i; add_y = ~a_i; add_cin = flags_in_i[1]; end
         OP_ORR:         begin is_arith = 1'b0; logic_res = a_i | b_i; end
         OP_MOV:         begin is_arith = 1'b0; logic_res = b_i; end
         OP_BIC:         begin is_arith = 1'b0; logic_res = a_i & ~b_i; end
         OP_MVN:         begin is_arith = 1'b0; logic_res = ~b_i; end
         default:        begin is_arith = 1'b1; end
      endcase
      sum       = {1'b0, add_x} + {1'b0, add_y} + {{DATA_WIDTH{1'b0}}, add_cin};
      alu_res   = is_arith ? sum[DATA_WIDTH-1:0] : logic_res;
      alu_c     = is_arith ? sum[DATA_WIDTH] : flags_in_i[1];
      alu_v     = is_arith ? ((add_x[DATA_WIDTH-1] == add_y[DATA_WIDTH-1]) &&
                              (sum[DATA_WIDTH-1] != add_x[DATA_WIDTH-1])) : flags_in_i[0];
      is_test   = (opcode_i[3:2] == 2'b10);
      alu_fwe   = set_flags_i || is_test;
      alu_flags = alu_fwe ? {alu_res[DATA_WIDTH-1], ~|alu_res, alu_c, alu_v} : flags_in_i;
   end

   // One shift-add step: the accept edge takes the first chunk straight from the inputs
   always_comb begin
      if (state_q == S_MUL) begin
         step_acc_in = acc_q;
         step_mcand  = mcand_q;
         step_mplier = mplier_q;
         mul_sf      = msf_q;
         mul_fin     = mflags_q;
         mul_tag     = mtag_q;
      end else begin
         step_acc_in = accumulate_i ? c_i : '0;
         step_mcand  = a_i;
         step_mplier = b_i;
         mul_sf      = set_flags_i;
         mul_fin     = flags_in_i;
         mul_tag     = tag_in_i;
      end
      chunk_ext              = '0;
      chunk_ext[CHUNK-1:0]   = step_mplier[CHUNK-1:0];
      step_acc               = step_acc_in + step_mcand * chunk_ext;
      mul_flags              = mul_sf ? {step_acc[DATA_WIDTH-1], ~|step_acc, mul_fin[1:0]} : mul_fin;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      msf_d    = msf_q;
      mflags_d = mflags_q;
      mtag_d   = mtag_q;
      res_d    = res_q;
      fout_d   = fout_q;
      fwe_d    = fwe_q;
      rwe_d    = rwe_q;
      tag_d    = tag_q;
      case (state_q)
         S_MUL: begin
            acc_d    = step_acc;
            mcand_d  = step_mcand << CHUNK;
            mplier_d = step_mplier >> CHUNK;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               res_d   = step_acc;
               fout_d  = mul_flags;
               fwe_d   = mul_sf;
               rwe_d   = 1'b1;
               tag_d   = mul_tag;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (accept) begin
               if (!is_mul_i) begin
                  state_d = S_DONE;
                  res_d   = alu_res;
                  fout_d  = alu_flags;
                  fwe_d   = alu_fwe;
                  rwe_d   = ~is_test;
                  tag_d   = tag_in_i;
               end else if (MUL_CYCLES == 1) begin
                  state_d = S_DONE;
                  res_d   = step_acc;
                  fout_d  = mul_flags;
                  fwe_d   = set_flags_i;
                  rwe_d   = 1'b1;
                  tag_d   = tag_in_i;
               end else begin
                  state_d  = S_MUL;
                  cnt_d    = CW'(1);
                  acc_d    = step_acc;
                  mcand_d  = step_mcand << CHUNK;
                  mplier_d = step_mplier >> CHUNK;
                  msf_d    = set_flags_i;
                  mflags_d = flags_in_i;
                  mtag_d   = tag_in_i;
               end
            end else if ((state_q == S_DONE) && out_ready_i) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         msf_q    <= 1'b0;
         mflags_q <= '0;
         mtag_q   <= '0;
         res_q    <= '0;
         fout_q   <= '0;
         fwe_q    <= 1'b0;
         rwe_q    <= 1'b0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         msf_q    <= msf_d;
         mflags_q <= mflags_d;
         mtag_q   <= mtag_d;
         res_q    <= res_d;
         fout_q   <= fout_d;
         fwe_q    <= fwe_d;
         rwe_q    <= rwe_d;
         tag_q    <= tag_d;
      end
   end

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, handshaked successor to the combinational processor ALU.
- Executes the full 16-opcode data-processing set plus mul/mla, and generates correct NZCV flags.
- Sits between the control unit's operand-read stage and its writeback stage.
- Single-cycle ops complete in one clock; multiplies are iterative over MUL_CYCLES clocks; results are held until consumed.

Parameters:
- DATA_WIDTH, 32, operand/result width (>=8).
- MUL_CYCLES, 4, cycles from mul acceptance to out_valid (1..DATA_WIDTH).
- TAG_WIDTH, 4, width of destination-register tag carried through.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept operation this cycle.
- opcode  input  4  data-processing opcode (ARM encoding); ignored when is_mul=1.
- is_mul  input  1  1 = multiply class.
- accumulate  input  1  with is_mul: 0 = mul, 1 = mla.
- set_flags  input  1  S bit.
- a  input  DATA_WIDTH  Rn (mul: Rm).
- b  input  DATA_WIDTH  operand2 (mul: Rs).
- c  input  DATA_WIDTH  accumulator (mla only).
- flags_in  input  4  current NZCV (bit3=N .. bit0=V).
- tag_in  input  TAG_WIDTH  destination register index.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  DATA_WIDTH  operation result.
- flags_out  output  4  new NZCV.
- flags_we  output  1  flags_out must be written to CPSR.
- result_we  output  1  result must be written to tag_out.
- tag_out  output  TAG_WIDTH  captured tag_in.
- busy  output  1  state != IDLE.

Behaviour:
- Handshake:
  - Accept on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM states:
  - IDLE: accept non-mul -> DONE; accept mul -> MUL.
  - MUL: counter runs 1..MUL_CYCLES-1, then -> DONE. With MUL_CYCLES=1, mul goes straight to DONE.
  - DONE: out_valid=1 and all outputs stable. On out_ready: if a new op is accepted the same cycle, go to DONE or MUL per that op; otherwise -> IDLE.
- Latency:
  - Non-mul: out_valid on the cycle after acceptance.
  - Mul: out_valid MUL_CYCLES cycles after acceptance.
  - Back-to-back non-mul ops sustain one result per cycle when out_ready is held high.
- Operands, flags_in and tag_in are registered at acceptance; later input changes have no effect.
- Reset: state=IDLE, out_valid=0, result=0, flags_out=0, flags_we=0, result_we=0, tag_out=0, counter=0, busy=0. Reset mid-multiply or mid-DONE discards the operation; no output is produced.
- Opcodes (C = flags_in[1]):
  - and a&b; eor a^b; sub a-b; rsb b-a; add a+b; adc a+b+C; sbc a-b-!C; rsc b-a-!C.
  - tst a&b; teq a^b; cmp a-b; cmn a+b.
  - orr a|b; mov b; bic a&~b; mvn ~b (bitwise).
- Arithmetic is computed at DATA_WIDTH+1 bits; result is truncated to DATA_WIDTH.
- result_we: 0 for tst/teq/cmp/cmn, 1 otherwise. For tst/teq/cmp/cmn, result still carries the computed value.
- flags_we = set_flags || opcode in {tst,teq,cmp,cmn}. If flags_we=0, flags_out = flags_in.
- Flag computation:
  - N = result MSB; Z = (result==0).
  - Add-type ops: C = carry out.
  - Subtract-type ops: C = NOT borrow (a-b with a>=b unsigned gives C=1).
  - Arithmetic ops: V = signed overflow.
  - Logical ops and mov/mvn: C and V pass through from flags_in.
- Multiply:
  - result = low DATA_WIDTH bits of a*b (+c for mla).
  - N and Z are updated only if set_flags; C and V always pass through.
  - result_we=1.

Test Plan:
- rst high 2 cycles mid-mul (a=3, b=5) -> out_valid stays 0, busy=0, all outputs 0; next op is accepted normally.
- add a=0xFFFFFFFF, b=1, set_flags=1, tag_in=7 -> next cycle out_valid=1, result=0, NZCV=0110, result_we=1, tag_out=7.
- cmp a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0x80000000, NZCV=1001, flags_we=1, result_we=0.
- mla a=6, b=7, c=8, MUL_CYCLES=4 -> out_valid exactly 4 cycles after acceptance, result=50; in_ready=0 during MUL.
- Three back-to-back adds with out_ready=1 -> three consecutive out_valid cycles, results in order. Repeat with out_ready=0 for 3 cycles -> result held stable, in_ready=0 until out_ready rises.
- sbc a=5, b=5, flags_in C=0 -> result=0xFFFFFFFF, N=1, C=0. mvn b=0 -> 0xFFFFFFFF with C/V equal to flags_in.
